// File: rtl/vga_disp_ctrl_if.sv
// Buffer-side and VGA-pin bundle for the edge-frame read sequencer.
// master = the display controller, slave = the frame buffer / writer / pins.
interface vga_disp_ctrl_if;
  logic        wr_end;
  logic        rd_q;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic        rd_end;
  logic        rd_addr_sel;
  logic        vga_hs;
  logic        vga_vs;
  logic [15:0] vga_rgb;

  modport master (
    input  wr_end, rd_q,
    output rd_addr, rd_en, rd_end, rd_addr_sel, vga_hs, vga_vs, vga_rgb
  );

  modport slave (
    output wr_end, rd_q,
    input  rd_addr, rd_en, rd_end, rd_addr_sel, vga_hs, vga_vs, vga_rgb
  );
endinterface

// File: rtl/vga_disp_ctrl.sv
// Read-side sequencer for the ping-pong 1-bit edge-frame buffer.
// Generates VGA raster timing, reads the stored window out of the bank not
// being written, swaps banks on frame boundaries once the writer has a full
// frame, and drives sync plus RGB565 to the pins with the read latency
// compensated so pixel (x,y) appears 2+RD_LAT cycles after the counters.
module vga_disp_ctrl #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FRONT  = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BACK   = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FRONT  = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BACK   = 33,
  parameter int          WIN_X0   = 160,
  parameter int          WIN_W    = 320,
  parameter int          WIN_Y0   = 140,
  parameter int          WIN_H    = 200,
  parameter int          RD_LAT   = 1,
  parameter logic [15:0] FG_RGB   = 16'hFFFF,
  parameter logic [15:0] BG_RGB   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_disp_ctrl_if.master   bus
);

  localparam int H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW         = $clog2(H_TOTAL);
  localparam int VW         = $clog2(V_TOTAL);
  localparam int PIPE       = 1 + RD_LAT;
  localparam int H_SYNC_BEG = H_ACTIVE + H_FRONT;
  localparam int H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int V_SYNC_BEG = V_ACTIVE + V_FRONT;
  localparam int V_SYNC_END = V_SYNC_BEG + V_SYNC;

  typedef enum logic [0:0] {
    WAIT_FIRST = 1'b0,
    SHOW       = 1'b1
  } state_t;

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  state_t            state;

  logic              h_last;
  logic              v_last;
  logic              frame_end;
  logic              active;
  logic              window;
  logic              hs_n;
  logic              vs_n;

  logic [15:0]       rd_addr;
  logic              rd_en;
  logic              rd_end;
  logic              rd_addr_sel;

  logic [PIPE-1:0]   act_d;
  logic [PIPE-1:0]   hs_d;
  logic [PIPE-1:0]   vs_d;
  logic [RD_LAT-1:0] en_d;

  logic              vga_hs;
  logic              vga_vs;
  logic [15:0]       vga_rgb;

  // Decode raster position into frame-end, active, window and sync levels.
  always_comb begin
    h_last    = 1'b0;
    v_last    = 1'b0;
    frame_end = 1'b0;
    active    = 1'b0;
    window    = 1'b0;
    hs_n      = 1'b1;
    vs_n      = 1'b1;
    h_last    = (int'(h_cnt) == H_TOTAL - 1);
    v_last    = (int'(v_cnt) == V_TOTAL - 1);
    frame_end = h_last && v_last;
    active    = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    window    = (int'(h_cnt) >= WIN_X0) && (int'(h_cnt) < WIN_X0 + WIN_W) &&
                (int'(v_cnt) >= WIN_Y0) && (int'(v_cnt) < WIN_Y0 + WIN_H);
    if ((int'(h_cnt) >= H_SYNC_BEG) && (int'(h_cnt) < H_SYNC_END)) begin
      hs_n = 1'b0;
    end else begin
      hs_n = 1'b1;
    end
    if ((int'(v_cnt) >= V_SYNC_BEG) && (int'(v_cnt) < V_SYNC_END)) begin
      vs_n = 1'b0;
    end else begin
      vs_n = 1'b1;
    end
  end

  // Horizontal and vertical raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      if (v_last) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + VW'(1);
      end
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Bank-swap FSM: wr_end is only looked at on the frame-end cycle, so a
  // swap (rd_end pulse + bank toggle) can happen at most once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_FIRST;
      rd_end      <= 1'b0;
      rd_addr_sel <= 1'b0;
    end else begin
      rd_end <= 1'b0;
      case (state)
        WAIT_FIRST: begin
          if (frame_end && bus.wr_end) begin
            rd_end      <= 1'b1;
            rd_addr_sel <= ~rd_addr_sel;
            state       <= SHOW;
          end
        end
        SHOW: begin
          if (frame_end && bus.wr_end) begin
            rd_end      <= 1'b1;
            rd_addr_sel <= ~rd_addr_sel;
          end
        end
        default: begin
          state <= WAIT_FIRST;
        end
      endcase
    end
  end

  // Read strobe one cycle behind the counters; address walks the window in
  // raster order and restarts on every frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= 16'd0;
    end else begin
      rd_en <= window && (state == SHOW);
      if (frame_end) begin
        rd_addr <= 16'd0;
      end else if (rd_en) begin
        rd_addr <= rd_addr + 16'd1;
      end
    end
  end

  // Delay counter-derived timing so it lines up with returning read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_d <= '0;
      hs_d  <= '1;
      vs_d  <= '1;
      en_d  <= '0;
    end else begin
      act_d[0] <= active;
      hs_d[0]  <= hs_n;
      vs_d[0]  <= vs_n;
      en_d[0]  <= rd_en;
      for (int i = 1; i < PIPE; i++) begin
        act_d[i] <= act_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        en_d[i] <= en_d[i-1];
      end
    end
  end

  // Registered pin drivers; a lit pixel needs a read issued in SHOW and rd_q=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
      vga_rgb <= BG_RGB;
    end else begin
      vga_hs <= hs_d[PIPE-1];
      vga_vs <= vs_d[PIPE-1];
      if (!act_d[PIPE-1]) begin
        vga_rgb <= BG_RGB;
      end else if (en_d[RD_LAT-1] && bus.rd_q) begin
        vga_rgb <= FG_RGB;
      end else begin
        vga_rgb <= BG_RGB;
      end
    end
  end

  assign bus.rd_addr     = rd_addr;
  assign bus.rd_en       = rd_en;
  assign bus.rd_end      = rd_end;
  assign bus.rd_addr_sel = rd_addr_sel;
  assign bus.vga_hs      = vga_hs;
  assign bus.vga_vs      = vga_vs;
  assign bus.vga_rgb     = vga_rgb;

endmodule

// File: tb/tb_vga_disp_ctrl.sv
// Scoreboard bench for vga_disp_ctrl on a shrunken raster (24x16 total,
// 8x5 window) so many frames fit in a short run. Stimulus pushes expected
// rd_end / read / lit-pixel events; a negedge monitor pops and compares.
module tb_vga_disp_ctrl;
  localparam int HA = 16, HF = 2, HSY = 4, HB = 2;
  localparam int VA = 12, VF = 1, VSY = 2, VB = 1;
  localparam int WX0 = 4, WW = 8, WY0 = 3, WH = 5;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_sel;
  bit   exp_show;
  ev_t  q_end[$];
  ev_t  q_rd[$];
  int   q_pix[$];

  always #5 clk = ~clk;

  vga_disp_ctrl_if bus ();

  vga_disp_ctrl #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .WIN_X0(WX0), .WIN_W(WW), .WIN_Y0(WY0), .WIN_H(WH),
    .RD_LAT(1), .FG_RGB(16'hFFFF), .BG_RGB(16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Cycles since reset release: equals the DUT raster position index.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Buffer model, latency 1: odd addresses hold 1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rd_q <= 1'b0;
    else        bus.rd_q <= bus.rd_en & bus.rd_addr[0];
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
    check({tag, "_rd_en"}, int'(bus.rd_en), 0);
    check({tag, "_rd_end"}, int'(bus.rd_end), 0);
    check({tag, "_rd_addr_sel"}, int'(bus.rd_addr_sel), 0);
    check({tag, "_vga_hs"}, int'(bus.vga_hs), 1);
    check({tag, "_vga_vs"}, int'(bus.vga_vs), 1);
    check({tag, "_vga_rgb"}, int'(bus.vga_rgb), 0);
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target) begin
      @(negedge clk);
      guard++;
      if (guard > 4 * FT) begin
        $display("FAIL wait_timeout: got cyc %0d, expected %0d", cyc, target);
        $fatal(1, "bench wait bound expired");
      end
    end
  endtask

  // Expected reads and lit pixels of frame f (only if the reader shows).
  task automatic push_frame(input int f);
    ev_t e;
    int  c;
    if (exp_show) begin
      for (int r = 0; r < WH; r++) begin
        for (int k = 0; k < WW; k++) begin
          c     = f * FT + (WY0 + r) * HT + WX0 + k;
          e.cyc = c + 1;
          e.val = r * WW + k;
          q_rd.push_back(e);
          if ((e.val % 2) == 1) q_pix.push_back(c + 3);
        end
      end
    end
  endtask

  // One writer frame: optional mid-frame raise, sample at frame end,
  // optional clear once rd_end is visible.
  task automatic run_frame(input int f, input bit raise, input bit clr, input bit push_next);
    ev_t e;
    int  base = f * FT;
    wait_cyc(base + FT / 2);
    check("sel_steady", int'(bus.rd_addr_sel), exp_sel);
    if (raise) bus.wr_end = 1'b1;
    wait_cyc(base + FT - 1);
    if (bus.wr_end) begin
      exp_sel  = exp_sel ^ 1;
      exp_show = 1'b1;
      e.cyc    = base + FT;
      e.val    = exp_sel;
      q_end.push_back(e);
    end
    wait_cyc(base + FT);
    if (clr) bus.wr_end = 1'b0;
    if (push_next) push_frame(f + 1);
  endtask

  // Monitor: pops expectations when the DUT presents events; checks sync every cycle.
  always @(negedge clk) begin
    ev_t e;
    int  p, h, v, ehs, evs, px;
    if (rst_n === 1'b1) begin
      while (q_end.size() > 0 && q_end[0].cyc < cyc) begin
        e = q_end.pop_front();
        check("rd_end_missing", 0, e.cyc);
      end
      while (q_rd.size() > 0 && q_rd[0].cyc < cyc) begin
        e = q_rd.pop_front();
        check("rd_en_missing", 0, e.cyc);
      end
      while (q_pix.size() > 0 && q_pix[0] < cyc) begin
        px = q_pix.pop_front();
        check("pixel_missing", 0, px);
      end
      if (bus.rd_end) begin
        if (q_end.size() == 0) check("rd_end_spurious", 1, 0);
        else begin
          e = q_end.pop_front();
          check("rd_end_cyc", cyc, e.cyc);
          check("rd_end_sel", int'(bus.rd_addr_sel), e.val);
        end
      end
      if (bus.rd_en) begin
        if (q_rd.size() == 0) check("rd_en_spurious", 1, 0);
        else begin
          e = q_rd.pop_front();
          check("rd_en_cyc", cyc, e.cyc);
          check("rd_addr", int'(bus.rd_addr), e.val);
        end
      end
      if (bus.vga_rgb == 16'hFFFF) begin
        if (q_pix.size() == 0) check("pixel_spurious", 1, 0);
        else begin
          px = q_pix.pop_front();
          check("pixel_cyc", cyc, px);
        end
      end else begin
        check("rgb_bg", int'(bus.vga_rgb), 0);
      end
      p   = cyc - 3;
      ehs = 1;
      evs = 1;
      if (p >= 0) begin
        h = p % HT;
        v = (p / HT) % VT;
        if (h >= HA + HF && h < HA + HF + HSY) ehs = 0;
        if (v >= VA + VF && v < VA + VF + VSY) evs = 0;
      end
      check("vga_hs", int'(bus.vga_hs), ehs);
      check("vga_vs", int'(bus.vga_vs), evs);
    end
  end

  initial begin
    bit raise_p [0:12];
    bit clr_p   [0:12];
    raise_p = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    clr_p   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rst_n       = 1'b0;
    bus.wr_end  = 1'b0;
    exp_sel     = 0;
    exp_show    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("init");
    rst_n = 1'b1;

    // Two idle frames, swaps at ends of 2/5/8, then wr_end held across 9..12.
    for (int f = 0; f < 13; f++) begin
      run_frame(f, raise_p[f], clr_p[f], 1'b1);
    end

    check("sel_before_reset", int'(bus.rd_addr_sel), 1);
    wait_cyc(13 * FT + 5 * HT + 6);
    check("rd_en_before_reset", int'(bus.rd_en), 1);
    rst_n = 1'b0;
    q_end.delete();
    q_rd.delete();
    q_pix.delete();
    exp_sel  = 0;
    exp_show = 1'b0;
    #1;
    check_reset("midrst");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;

    // Back in WAIT_FIRST: idle frame, then one swap and one shown frame.
    run_frame(0, 1'b0, 1'b1, 1'b1);
    run_frame(1, 1'b1, 1'b1, 1'b1);
    run_frame(2, 1'b0, 1'b1, 1'b0);
    wait_cyc(3 * FT + 4);
    check("q_end_empty", q_end.size(), 0);
    check("q_rd_empty", q_rd.size(), 0);
    check("q_pix_empty", q_pix.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
